engine_stride_index_generator: RTL

ENGINE_STRIDE_INDEX_GENERATOR -- requirements
Module: engine_stride_index_generator

---
 rtl/engine_stride_index_generator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/engine_stride_index_generator.sv
// Stride index generator: emits a strided index sequence with chunk markers (out_last).
// Optional ENGINE_STRIDE_INDEX_COUNT_EN adds a saturating accepted-handshake counter.
module engine_stride_index_generator #(
   parameter int unsigned M_AXI_MEMORY_ADDR_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH              = M_AXI_MEMORY_ADDR_WIDTH,
   parameter int unsigned META_WIDTH              = 32,
   // {valid, increment, decrement, index_start, index_end, stride, granularity, meta}
   localparam int unsigned CfgWidth               = 3 + 4 * ADDR_WIDTH + META_WIDTH
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [CfgWidth-1:0]   config_in,
   input  logic                  start_in,
   input  logic                  pause_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic [META_WIDTH-1:0] out_meta,
`ifdef ENGINE_STRIDE_INDEX_COUNT_EN
   output logic [ADDR_WIDTH-1:0] out_count,
`endif
   output logic                  setup_ready_out,
   output logic                  busy_out,
   output logic                  done_out
);

   localparam int unsigned GranLsb   = META_WIDTH;
   localparam int unsigned StrideLsb = GranLsb + ADDR_WIDTH;
   localparam int unsigned EndLsb    = StrideLsb + ADDR_WIDTH;
   localparam int unsigned StartLsb  = EndLsb + ADDR_WIDTH;

   typedef enum logic [2:0] {
      StReset,
      StIdle,
      StSetup,
      StStart,
      StBusy,
      StPause,
      StDone
   } engine_stride_index_generator_state;

   engine_stride_index_generator_state state_q, state_d;

   logic                  incr_q, incr_d;
   logic                  decr_q, decr_d;
   logic [ADDR_WIDTH-1:0] start_q, start_d;
   logic [ADDR_WIDTH-1:0] end_q, end_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [ADDR_WIDTH-1:0] gran_q, gran_d;
   logic [META_WIDTH-1:0] meta_q, meta_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] gcnt_q, gcnt_d;

   logic                  cfg_valid;
   logic                  zero_len;
   logic [ADDR_WIDTH:0]   sum;
   logic [ADDR_WIDTH-1:0] diff;
   logic [ADDR_WIDTH-1:0] next_idx;
   logic [ADDR_WIDTH-1:0] gran_eff;
   logic                  final_idx;
   logic                  gran_hit;

   assign cfg_valid = config_in[CfgWidth-1];

   assign zero_len = (!incr_q && !decr_q) || (stride_q == '0) ||
                     (incr_q ? (start_q >= end_q) : (start_q <= end_q));

   // Carry/borrow out of the step means the sequence would wrap the address space.
   assign sum       = {1'b0, idx_q} + {1'b0, stride_q};
   assign diff      = idx_q - stride_q;
   assign next_idx  = incr_q ? sum[ADDR_WIDTH-1:0] : diff;
   assign final_idx = incr_q ? (sum[ADDR_WIDTH] || (sum[ADDR_WIDTH-1:0] >= end_q))
                             : ((stride_q > idx_q) || (diff <= end_q));

   assign gran_eff = (gran_q == '0) ? ADDR_WIDTH'(1) : gran_q;
   assign gran_hit = (gcnt_q + ADDR_WIDTH'(1)) == gran_eff;

   assign out_valid       = (state_q == StBusy);
   assign out_last        = out_valid && (final_idx || gran_hit);
   assign out_index       = idx_q;
   assign out_meta        = meta_q;
   assign setup_ready_out = (state_q == StIdle);
   assign busy_out        = (state_q == StStart) || (state_q == StBusy) || (state_q == StPause);
   assign done_out        = (state_q == StDone);

   always_comb begin
      state_d  = state_q;
      incr_d   = incr_q;
      decr_d   = decr_q;
      start_d  = start_q;
      end_d    = end_q;
      stride_d = stride_q;
      gran_d   = gran_q;
      meta_d   = meta_q;
      idx_d    = idx_q;
      gcnt_d   = gcnt_q;
      unique case (state_q)
         StReset: state_d = StIdle;
         StIdle: begin
            if (cfg_valid) begin
               incr_d   = config_in[CfgWidth-2];
               decr_d   = config_in[CfgWidth-3];
               start_d  = config_in[StartLsb +: ADDR_WIDTH];
               end_d    = config_in[EndLsb +: ADDR_WIDTH];
               stride_d = config_in[StrideLsb +: ADDR_WIDTH];
               gran_d   = config_in[GranLsb +: ADDR_WIDTH];
               meta_d   = config_in[META_WIDTH-1:0];
               state_d  = StSetup;
            end
         end
         StSetup: begin
            if (start_in) state_d = StStart;
         end
         StStart: begin
            idx_d   = start_q;
            gcnt_d  = '0;
            state_d = zero_len ? StDone : StBusy;
         end
         StBusy: begin
            if (out_ready) begin
               if (final_idx) begin
                  state_d = StDone;
               end else begin
                  idx_d  = next_idx;
                  gcnt_d = gran_hit ? '0 : gcnt_q + ADDR_WIDTH'(1);
                  // Pause only once the presented index has been taken.
                  if (pause_in) state_d = StPause;
               end
            end
         end
         StPause: begin
            if (!pause_in) state_d = StBusy;
         end
         StDone: begin
            if (!start_in) state_d = StIdle;
         end
         default: state_d = StReset;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= StReset;
         incr_q   <= 1'b0;
         decr_q   <= 1'b0;
         start_q  <= '0;
         end_q    <= '0;
         stride_q <= '0;
         gran_q   <= '0;
         meta_q   <= '0;
         idx_q    <= '0;
         gcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         incr_q   <= incr_d;
         decr_q   <= decr_d;
         start_q  <= start_d;
         end_q    <= end_d;
         stride_q <= stride_d;
         gran_q   <= gran_d;
         meta_q   <= meta_d;
         idx_q    <= idx_d;
         gcnt_q   <= gcnt_d;
      end
   end

`ifdef ENGINE_STRIDE_INDEX_COUNT_EN
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == StSetup) && start_in) begin
         cnt_d = '0;
      end else if (out_valid && out_ready && (cnt_q != '1)) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_count = cnt_q;
`endif

endmodule
